// File: rtl/rsbus_r2d_frame_buffer.sv
// Frame buffer between the ring-to-device extractor and the device port: short/long slot queues, whole-frame replay.
// Optional overflow drop and sticky o_err when RSBUS_R2D_FRAME_BUFFER_OVF_CHECK_EN is defined.
module rsbus_r2d_frame_buffer #(
    parameter int S_LEN   = 2,
    parameter int L_LEN   = 9,
    parameter int S_DEPTH = 4,
    parameter int L_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frm_i_stb,
    input  logic        frm_i_sof,
    input  logic [3:0]  frm_i_iid,
    input  logic [71:0] frm_i_bus,
    output logic [1:0]  frm_i_rdy,
    output logic        dev_o_stb,
    output logic        dev_o_sof,
    output logic        dev_o_len,
    output logic [3:0]  dev_o_iid,
    output logic [71:0] dev_o_bus,
    input  logic        dev_i_ack,
    output logic        o_err
);
    // state  | meaning
    // IDLE   | no frame being replayed; arbitrate between queues
    // SEND_S | replaying the short slot at s_rd_ptr
    // SEND_L | replaying the long slot at l_rd_ptr
    typedef enum logic [1:0] {IDLE, SEND_S, SEND_L} state_t;

    localparam int SPW = $clog2(S_DEPTH);
    localparam int LPW = $clog2(L_DEPTH);
    localparam int SCW = $clog2(S_DEPTH + 1);
    localparam int LCW = $clog2(L_DEPTH + 1);
    localparam int SIW = $clog2(S_LEN);
    localparam int LIW = $clog2(L_LEN);
    localparam int IW  = (SIW > LIW) ? SIW : LIW;

    logic [71:0]        s_mem [S_DEPTH][S_LEN];
    logic [71:0]        l_mem [L_DEPTH][L_LEN];
    logic [3:0]         s_iid [S_DEPTH];
    logic [3:0]         l_iid [L_DEPTH];
    logic [S_DEPTH-1:0] s_vld;
    logic [L_DEPTH-1:0] l_vld;
    logic [SCW-1:0]     s_count;
    logic [LCW-1:0]     l_count;
    logic [SPW-1:0]     s_wr_ptr, s_wr_slot, s_rd_ptr;
    logic [LPW-1:0]     l_wr_ptr, l_wr_slot, l_rd_ptr;
    logic               wr_active, wr_long;
    logic [IW-1:0]      wr_idx, rd_idx;
    logic               rr_long_last;
    state_t             state, state_nx;

    logic sof_in, sof_long, accept, cont, wr_last, close;
    logic s_inc, l_inc, s_dec, l_dec, rd_last, fire;

    assign sof_in   = frm_i_stb && frm_i_sof;
    assign sof_long = frm_i_bus[39];
`ifdef RSBUS_R2D_FRAME_BUFFER_OVF_CHECK_EN
    logic q_full, err_q;
    assign q_full = sof_long ? (l_count == LCW'(L_DEPTH)) : (s_count == SCW'(S_DEPTH));
    assign accept = sof_in && !q_full;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (sof_in && q_full)
            err_q <= 1'b1;
    end
    assign o_err = err_q;
`else
    assign accept = sof_in;
    assign o_err  = 1'b0;
`endif

    // A new sof or a dropped stb also closes the open frame; missing words replay as whatever the slot held.
    assign cont    = wr_active && frm_i_stb && !frm_i_sof;
    assign wr_last = cont && (wr_idx == (wr_long ? IW'(L_LEN - 1) : IW'(S_LEN - 1)));
    assign close   = wr_active && (!frm_i_stb || frm_i_sof || wr_last);
    assign s_inc   = accept && !sof_long;
    assign l_inc   = accept && sof_long;

    assign fire    = dev_o_stb && dev_i_ack;
    assign rd_last = (state == SEND_L) ? (rd_idx == IW'(L_LEN - 1)) : (rd_idx == IW'(S_LEN - 1));
    assign s_dec   = fire && (state == SEND_S) && rd_last;
    assign l_dec   = fire && (state == SEND_L) && rd_last;

    assign frm_i_rdy = rst ? 2'b00 : {l_count <= LCW'(L_DEPTH - 2), s_count <= SCW'(S_DEPTH - 2)};

    always_ff @(posedge clk) begin
        if (accept) begin
            if (sof_long) begin
                l_mem[l_wr_ptr][0] <= frm_i_bus;
                l_iid[l_wr_ptr]    <= frm_i_iid;
            end else begin
                s_mem[s_wr_ptr][0] <= frm_i_bus;
                s_iid[s_wr_ptr]    <= frm_i_iid;
            end
        end
        if (cont) begin
            if (wr_long)
                l_mem[l_wr_slot][wr_idx[LIW-1:0]] <= frm_i_bus;
            else
                s_mem[s_wr_slot][wr_idx[SIW-1:0]] <= frm_i_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_active <= 1'b0;
            wr_long   <= 1'b0;
            wr_idx    <= '0;
            s_wr_ptr  <= '0;
            l_wr_ptr  <= '0;
            s_wr_slot <= '0;
            l_wr_slot <= '0;
            s_vld     <= '0;
            l_vld     <= '0;
            s_count   <= '0;
            l_count   <= '0;
        end else begin
            if (close) begin
                wr_active <= 1'b0;
                if (wr_long)
                    l_vld[l_wr_slot] <= 1'b1;
                else
                    s_vld[s_wr_slot] <= 1'b1;
            end
            if (s_dec)
                s_vld[s_rd_ptr] <= 1'b0;
            if (l_dec)
                l_vld[l_rd_ptr] <= 1'b0;
            if (cont)
                wr_idx <= wr_idx + 1'b1;
            if (accept) begin
                wr_active <= 1'b1;
                wr_long   <= sof_long;
                wr_idx    <= IW'(1);
                if (sof_long) begin
                    l_wr_slot <= l_wr_ptr;
                    l_wr_ptr  <= (l_wr_ptr == LPW'(L_DEPTH - 1)) ? '0 : l_wr_ptr + 1'b1;
                end else begin
                    s_wr_slot <= s_wr_ptr;
                    s_wr_ptr  <= (s_wr_ptr == SPW'(S_DEPTH - 1)) ? '0 : s_wr_ptr + 1'b1;
                end
            end
            case ({s_inc, s_dec})
                2'b10:   s_count <= s_count + 1'b1;
                2'b01:   s_count <= s_count - 1'b1;
                default: s_count <= s_count;
            endcase
            case ({l_inc, l_dec})
                2'b10:   l_count <= l_count + 1'b1;
                2'b01:   l_count <= l_count - 1'b1;
                default: l_count <= l_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rd_idx       <= '0;
            s_rd_ptr     <= '0;
            l_rd_ptr     <= '0;
            rr_long_last <= 1'b1;
        end else begin
            state <= state_nx;
            if (fire)
                rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
            if (s_dec) begin
                s_rd_ptr     <= (s_rd_ptr == SPW'(S_DEPTH - 1)) ? '0 : s_rd_ptr + 1'b1;
                rr_long_last <= 1'b0;
            end
            if (l_dec) begin
                l_rd_ptr     <= (l_rd_ptr == LPW'(L_DEPTH - 1)) ? '0 : l_rd_ptr + 1'b1;
                rr_long_last <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        dev_o_stb = 1'b0;
        dev_o_sof = 1'b0;
        dev_o_len = 1'b0;
        dev_o_iid = 4'd0;
        dev_o_bus = '0;
        case (state)
            IDLE: begin
                if (s_vld[s_rd_ptr] && (!l_vld[l_rd_ptr] || rr_long_last))
                    state_nx = SEND_S;
                else if (l_vld[l_rd_ptr])
                    state_nx = SEND_L;
            end
            SEND_S: begin
                dev_o_stb = !rst;
                dev_o_sof = (rd_idx == '0);
                dev_o_iid = s_iid[s_rd_ptr];
                dev_o_bus = s_mem[s_rd_ptr][rd_idx[SIW-1:0]];
                if (s_dec)
                    state_nx = IDLE;
            end
            SEND_L: begin
                dev_o_stb = !rst;
                dev_o_sof = (rd_idx == '0);
                dev_o_len = 1'b1;
                dev_o_iid = l_iid[l_rd_ptr];
                dev_o_bus = l_mem[l_rd_ptr][rd_idx[LIW-1:0]];
                if (l_dec)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rsbus_r2d_frame_buffer.sv
// Scoreboard bench for rsbus_r2d_frame_buffer: per-length expected word queues filled as frames are driven.
// Exercises RSBUS_R2D_FRAME_BUFFER_OVF_CHECK_EN when that macro is defined.
module tb_rsbus_r2d_frame_buffer;
    localparam int S_LEN   = 2;
    localparam int L_LEN   = 9;
    localparam int S_DEPTH = 4;
    localparam int L_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        frm_i_stb, frm_i_sof;
    logic [3:0]  frm_i_iid;
    logic [71:0] frm_i_bus;
    logic [1:0]  frm_i_rdy;
    logic        dev_o_stb, dev_o_sof, dev_o_len;
    logic [3:0]  dev_o_iid;
    logic [71:0] dev_o_bus;
    logic        dev_i_ack;
    logic        o_err;

    rsbus_r2d_frame_buffer #(
        .S_LEN(S_LEN), .L_LEN(L_LEN), .S_DEPTH(S_DEPTH), .L_DEPTH(L_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .frm_i_stb(frm_i_stb), .frm_i_sof(frm_i_sof), .frm_i_iid(frm_i_iid),
        .frm_i_bus(frm_i_bus), .frm_i_rdy(frm_i_rdy),
        .dev_o_stb(dev_o_stb), .dev_o_sof(dev_o_sof), .dev_o_len(dev_o_len),
        .dev_o_iid(dev_o_iid), .dev_o_bus(dev_o_bus), .dev_i_ack(dev_i_ack),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [76:0] s_exp[$];
    logic [76:0] l_exp[$];
    bit          ord[$];
    int          gaps[$];
    int          cyc = 0;
    int          last_end = 0;
    int          mon_idx = 0;
    int          l_acked = 0;

    task automatic check_val(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Every offered word is compared against the queue head, so stalled words are also checked for stability.
    always @(negedge clk) begin
        logic [76:0] got;
        int          flen;
        cyc++;
        if (dev_o_stb) begin
            got = {dev_o_sof, dev_o_iid, dev_o_bus};
            if (dev_o_len) begin
                check_val("l_sb_nonempty", 80'(l_exp.size() != 0), 80'(1));
                if (l_exp.size() != 0) begin
                    check_val("l_word", 80'(got), 80'(l_exp[0]));
                    if (dev_i_ack) void'(l_exp.pop_front());
                end
            end else begin
                check_val("s_sb_nonempty", 80'(s_exp.size() != 0), 80'(1));
                if (s_exp.size() != 0) begin
                    check_val("s_word", 80'(got), 80'(s_exp[0]));
                    if (dev_i_ack) void'(s_exp.pop_front());
                end
            end
            if (dev_i_ack) begin
                flen = dev_o_len ? L_LEN : S_LEN;
                if (dev_o_sof) begin
                    mon_idx = 0;
                    ord.push_back(dev_o_len);
                    gaps.push_back(cyc - last_end);
                end
                if (dev_o_len) l_acked++;
                if (mon_idx == flen - 1) begin
                    last_end = cyc;
                    mon_idx  = 0;
                end else begin
                    mon_idx++;
                end
            end
        end
    end

    task automatic do_reset(input bit junk_on_release);
        rst       = 1'b1;
        frm_i_stb = 1'b0;
        frm_i_sof = 1'b0;
        frm_i_iid = 4'd0;
        frm_i_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rdy", 80'(frm_i_rdy), 80'(2'b00));
        check_val("rst_stb", 80'(dev_o_stb), 80'(0));
        s_exp.delete();
        l_exp.delete();
        ord.delete();
        gaps.delete();
        mon_idx  = 0;
        last_end = 0;
        l_acked  = 0;
        rst = 1'b0;
        if (junk_on_release) begin
            frm_i_stb = 1'b1;
            frm_i_bus = 72'hDEAD;
        end
        @(posedge clk);
        #1;
        frm_i_stb = 1'b0;
        check_val("post_rst_rdy", 80'(frm_i_rdy), 80'(2'b11));
        check_val("post_rst_err", 80'(o_err), 80'(0));
    endtask

    task automatic drive_word(input bit is_long, input bit sof, input logic [3:0] iid,
                              input logic [71:0] w, input bit push);
        frm_i_stb = 1'b1;
        frm_i_sof = sof;
        frm_i_iid = iid;
        frm_i_bus = w;
        if (push) begin
            if (is_long) l_exp.push_back({sof, iid, w});
            else         s_exp.push_back({sof, iid, w});
        end
    endtask

    task automatic send_frame(input bit is_long, input logic [3:0] iid, input logic [71:0] base,
                              input bit push);
        logic [71:0] w;
        int          len;
        len = is_long ? L_LEN : S_LEN;
        for (int i = 0; i < len; i++) begin
            w = base + 72'(i);
            if (i == 0) w[39] = is_long;
            drive_word(is_long, i == 0, iid, w, push);
            @(posedge clk);
            #1;
        end
        frm_i_stb = 1'b0;
        frm_i_sof = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((s_exp.size() != 0 || l_exp.size() != 0) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_timeout", 80'(n >= max), 80'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  pat;
        logic [71:0] w;
        int          n;
        dev_i_ack = 1'b1;

        // single short frame; a stray word on reset release must be ignored
        do_reset(1'b1);
        send_frame(1'b0, 4'd3, 72'hA0, 1'b1);
        wait_drain(50);
        check_val("t1_s_count", 80'(dut.s_count), 80'(0));

        // fill short queue under back-pressure, then drain in order
        do_reset(1'b0);
        dev_i_ack = 1'b0;
        send_frame(1'b0, 4'd1, {24'h000011, 48'h0}, 1'b1);
        send_frame(1'b0, 4'd2, {24'h000012, 48'h0}, 1'b1);
        check_val("fill_rdy_2", 80'(frm_i_rdy), 80'(2'b11));
        send_frame(1'b0, 4'd5, {24'h000013, 48'h0}, 1'b1);
        check_val("fill_rdy_3", 80'(frm_i_rdy), 80'(2'b10));
        check_val("fill_count", 80'(dut.s_count), 80'(3));
        dev_i_ack = 1'b1;
        wait_drain(100);
        check_val("fill_rdy_back", 80'(frm_i_rdy), 80'(2'b11));
        check_val("fill_s_count", 80'(dut.s_count), 80'(0));

        // round-robin: short, long, short with one bubble between frames
        do_reset(1'b0);
        dev_i_ack = 1'b0;
        send_frame(1'b0, 4'd6, {24'h000021, 48'h0}, 1'b1);
        send_frame(1'b0, 4'd7, {24'h000022, 48'h0}, 1'b1);
        send_frame(1'b1, 4'd8, {24'h000023, 48'h0}, 1'b1);
        dev_i_ack = 1'b1;
        wait_drain(100);
        check_val("rr_frames", 80'(ord.size()), 80'(3));
        if (ord.size() == 3) begin
            check_val("rr_order", 80'({ord[0], ord[1], ord[2]}), 80'(3'b010));
            check_val("rr_gap1", 80'(gaps[1]), 80'(2));
            check_val("rr_gap2", 80'(gaps[2]), 80'(2));
        end
        check_val("rr_long_words", 80'(l_acked), 80'(L_LEN));

        // long frame with ack pattern 1,0,0,1
        do_reset(1'b0);
        dev_i_ack = 1'b0;
        pat = 4'b1001;
        send_frame(1'b1, 4'd9, {24'h000031, 48'h0}, 1'b1);
        n = 0;
        while (l_exp.size() != 0 && n < 200) begin
            dev_i_ack = pat[n % 4];
            @(posedge clk);
            #1;
            n++;
        end
        check_val("bp_timeout", 80'(n >= 200), 80'(0));
        dev_i_ack = 1'b1;
        check_val("bp_acked", 80'(l_acked), 80'(L_LEN));

        // second sof on the same cycle the first frame's last word is acked
        do_reset(1'b0);
        dev_i_ack = 1'b1;
        send_frame(1'b0, 4'd10, {24'h000041, 48'h0}, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dev_o_stb && !dev_o_sof && !dev_o_len) && n < 20);
        check_val("simul_timeout", 80'(n >= 20), 80'(0));
        w = {24'h000042, 48'h0};
        drive_word(1'b0, 1'b1, 4'd11, w, 1'b1);
        @(posedge clk);
        #1;
        check_val("simul_count", 80'(dut.s_count), 80'(1));
        drive_word(1'b0, 1'b0, 4'd11, w + 72'd1, 1'b1);
        @(posedge clk);
        #1;
        frm_i_stb = 1'b0;
        frm_i_sof = 1'b0;
        wait_drain(50);
        check_val("simul_end_count", 80'(dut.s_count), 80'(0));

`ifdef RSBUS_R2D_FRAME_BUFFER_OVF_CHECK_EN
        // third long frame while the long queue is full is dropped
        do_reset(1'b0);
        dev_i_ack = 1'b0;
        send_frame(1'b1, 4'd12, {24'h000051, 48'h0}, 1'b1);
        send_frame(1'b1, 4'd13, {24'h000052, 48'h0}, 1'b1);
        check_val("ovf_err_before", 80'(o_err), 80'(0));
        send_frame(1'b1, 4'd14, {24'h000053, 48'h0}, 1'b0);
        check_val("ovf_err_set", 80'(o_err), 80'(1));
        check_val("ovf_l_count", 80'(dut.l_count), 80'(2));
        dev_i_ack = 1'b1;
        wait_drain(100);
        repeat (15) @(posedge clk);
        #1;
        check_val("ovf_frames", 80'(ord.size()), 80'(2));
        check_val("ovf_err_sticky", 80'(o_err), 80'(1));
`else
        check_val("o_err_off", 80'(o_err), 80'(0));
`endif

        repeat (5) @(posedge clk);
        #1;
        check_val("end_s_empty", 80'(s_exp.size()), 80'(0));
        check_val("end_l_empty", 80'(l_exp.size()), 80'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rsbus_r2d_frame_buffer.md
Name: rsbus_r2d_frame_buffer

Overview:
- Sits directly downstream of the ring-to-device extractor.
- Accepts extracted frames (stb/sof/iid/72-bit words) into two frame-slot queues, one for short frames and one for long frames.
- Drives the per-length ready pair `frm_i_rdy[1:0]` back to the extractor.
- Replays frames whole to the device side over a word-level valid/ack handshake, with round-robin between the queues.

Parameters:
- S_LEN, 2: words per short frame (header included); must be >= 2.
- L_LEN, 9: words per long frame (header included); must be >= 2.
- S_DEPTH, 4: short frame slots; must be >= 2.
- L_DEPTH, 2: long frame slots; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- frm_i_stb  in  1  word valid; high for every word of an extracted frame.
- frm_i_sof  in  1  first (header) word of a frame.
- frm_i_iid  in  4  target interface id; valid with the header word.
- frm_i_bus  in  72  frame word; header bit 39 = length (0 short, 1 long).
- frm_i_rdy  out  2  [0] a short frame may be accepted; [1] a long frame may be accepted.
- dev_o_stb  out  1  output word valid.
- dev_o_sof  out  1  first word of the output frame.
- dev_o_len  out  1  length class of the current output frame.
- dev_o_iid  out  4  iid of the current output frame.
- dev_o_bus  out  72  output word.
- dev_i_ack  in  1  device consumes the word when dev_o_stb && dev_i_ack.
- o_err  out  1  sticky overflow flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - frm_i_rdy = 2'b00 during reset, then from the count equations on the first cycle after reset.
  - dev_o_stb = 0, dev_o_sof = 0, o_err = 0.
  - Queue counts, pointers and the round-robin flag are cleared; the FSM goes to IDLE.
- Reset mid-frame discards all partial and stored frames. Words arriving on the cycle reset is released with stb=1 and sof=0 are ignored until the next sof.
- Write side:
  - A word with frm_i_stb && frm_i_sof starts a frame.
  - The queue is chosen by frm_i_bus[39]. frm_i_iid is latched into the slot's iid field.
  - The slot count of that queue increments on this cycle, so the slot is reserved at sof.
  - Each following word with stb=1 writes at word index 1..LEN-1.
  - The frame completes after LEN words, or when stb drops. Unwritten words of a short-terminated frame are don't-care; the frame is still stored and replayed at full LEN.
  - A completed slot is marked readable on the cycle after its last word is written.
- Ready generation:
  - frm_i_rdy[0] = (s_count <= S_DEPTH-2); frm_i_rdy[1] = (l_count <= L_DEPTH-2).
  - Both are combinational from registered counts.
  - The margin of one slot covers the 2-cycle extractor decision latency; at most one accepted frame is ever in flight.
- Read FSM states:
  - IDLE:
    - If one queue has a readable slot, go to SEND of that queue.
    - If both have one, serve the queue not served last (round-robin flag); after reset the short queue has priority.
  - SEND_S / SEND_L:
    - dev_o_stb = 1, dev_o_sof = 1 on word 0.
    - dev_o_len and dev_o_iid are held constant for the whole frame.
    - The word index advances on ack.
    - On ack of word LEN-1: the slot is freed (count decrements, read pointer wraps modulo DEPTH), the round-robin flag updates, and the FSM goes to IDLE.
- Throughput: IDLE costs one bubble cycle between frames.
- Latency: a stored frame's first word appears no earlier than 2 cycles after its last input word.
- Simultaneous sof-write and last-word-read on the same queue: the count is unchanged; increment and decrement both apply.
- Pointer wrap: write and read pointers wrap from DEPTH-1 to 0.
- dev_o_bus must be stable while dev_o_stb && !dev_i_ack.

Optional Feature:
- Macro: RSBUS_R2D_FRAME_BUFFER_OVF_CHECK_EN.
- Defined:
  - A sof arriving when the target queue count == DEPTH is a protocol violation. The whole frame is dropped: no count change, no writes.
  - o_err sets on the next cycle and stays set until rst.
- Undefined:
  - o_err is tied 0.
  - A sof is always accepted; overflow behaviour is unspecified, and upstream honouring frm_i_rdy is a contract.

Test Plan:
- Single short frame, iid=4'd3, words 0xA0, 0xA1 with header bit39=0, dev_i_ack=1 constantly -> after reset frm_i_rdy=2'b11; the device sees sof+0xA0 then 0xA1, dev_o_len=0, dev_o_iid=3; s_count returns to 0.
- Fill short queue: three back-to-back short frames, ack=0 -> frm_i_rdy[0] drops on the cycle after the 3rd sof (count 3 > S_DEPTH-2=2) while frm_i_rdy[1] stays 1; releasing ack drains 3 frames in order and rdy[0] returns.
- Short and long both pending, ack=1 -> output order short, long, short (round-robin); one idle cycle between frames; long frame is 9 contiguous acked words.
- Back-pressure: long frame, ack toggling 1,0,0,1,... -> no word skipped or duplicated; dev_o_bus is stable while stalled; 9 acked words total.
- Simultaneous: 2nd short sof arrives on the same cycle the 1st frame's last word is acked -> s_count unchanged (1); both frames delivered intact.
- With RSBUS_R2D_FRAME_BUFFER_OVF_CHECK_EN: force 3 long frames with rdy ignored and ack=0 -> the third is dropped, o_err=1 next cycle and sticky; only 2 long frames are delivered. Without the macro, o_err stays 0.
